// File: rtl/msg_rom_streamer_if.sv
// msg_rom_streamer_if: valid/ready byte stream carrying characters to the display/UART.
//   data  : character (DATA_W bits), driven by master
//   valid : data valid, driven by master
//   ready : downstream accepts when valid & ready, driven by slave
interface msg_rom_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/msg_rom_streamer.sv
// msg_rom_streamer: streams one of NUM_MSG fixed messages from a ROM as a valid/ready byte
// stream with a programmable inter-character gap, one-shot or looping.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin playback (sampled only in IDLE); latches msg_sel and gap_div
//   msg_sel    : message slot to play
//   loop       : replay the message when it ends (live input)
//   gap_div    : idle cycles between characters
//   abort      : synchronous stop, highest priority
//   out        : master side of the character stream (data/valid/ready)
//   busy       : high outside IDLE
//   done       : one-cycle pulse on normal completion
//   chk_out    : XOR of all transferred bytes (only with MSG_CHKSUM_EN defined)
// The ROM contents come from the ROM_IMAGE parameter: byte at address a sits in bits
// [a*DATA_W +: DATA_W], slot m occupies addresses m*DEPTH .. m*DEPTH+DEPTH-1.
module msg_rom_streamer #(
    parameter int                              DATA_W    = 8,
    parameter int                              DEPTH     = 32,
    parameter int                              NUM_MSG   = 4,
    parameter int                              DIV_W     = 16,
    parameter logic [DATA_W-1:0]               TERM      = '0,
    parameter logic [NUM_MSG*DEPTH*DATA_W-1:0] ROM_IMAGE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    input  logic                       loop,
    input  logic [DIV_W-1:0]           gap_div,
    input  logic                       abort,
    msg_rom_streamer_if.master         out,
    output logic                       busy,
    output logic                       done
`ifdef MSG_CHKSUM_EN
    ,
    output logic [DATA_W-1:0]          chk_out
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(NUM_MSG);
    localparam int AW = $clog2(NUM_MSG * DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, GAP} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     sel;
    logic [IW-1:0]     idx;
    logic [DIV_W-1:0]  gap, cnt;
    logic [DATA_W-1:0] data;
    logic              emitted;
    logic [DATA_W-1:0] rom [NUM_MSG*DEPTH];
    logic [AW-1:0]     base;
    logic [DATA_W-1:0] cur, first;
    logic              wrap, last, is_term, valid, xfer;

    genvar g;
    for (g = 0; g < NUM_MSG * DEPTH; g++) begin : g_rom
        assign rom[g] = ROM_IMAGE[g*DATA_W +: DATA_W];
    end

    assign base    = AW'(sel) * AW'(DEPTH);
    assign cur     = rom[base + AW'(idx)];
    assign first   = rom[base];
    // Wrapping is decided while fetching: if the byte just reached is the terminator of a
    // non-empty looping message, slot byte 0 is loaded instead, so the wrap costs no cycle.
    assign wrap    = cur == TERM && loop && emitted;
    assign last    = idx == IW'(DEPTH - 1);
    assign is_term = data == TERM;
    assign valid   = state == EMIT && !is_term;
    assign xfer    = valid && out.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = EMIT;
            EMIT:    state_nx = is_term ? IDLE : !xfer ? EMIT : (last && !loop) ? IDLE :
                                gap != '0 ? GAP : FETCH;
            GAP:     state_nx = cnt == DIV_W'(1) ? FETCH : GAP;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_comb begin
        out.data  = data;
        out.valid = valid;
        busy      = state != IDLE;
        // A terminator reached in EMIT always ends: looping was already resolved in FETCH.
        done      = !abort && state == EMIT && (is_term || (xfer && last && !loop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '0;
            idx     <= '0;
            gap     <= '0;
            cnt     <= '0;
            data    <= '0;
            emitted <= 1'b0;
        end else if (abort) begin
            idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sel     <= msg_sel;
                    gap     <= gap_div;
                    idx     <= '0;
                    emitted <= 1'b0;
                end
                FETCH: begin
                    data <= wrap ? first : cur;
                    if (wrap) idx <= '0;
                end
                EMIT: if (is_term) begin
                    idx <= '0;
                end else if (xfer) begin
                    emitted <= 1'b1;
                    idx     <= last ? '0 : idx + 1'b1;
                    cnt     <= gap;
                end
                GAP: cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MSG_CHKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      chk_out <= '0;
        else if (abort)                  chk_out <= chk_out;
        else if (state == IDLE && start) chk_out <= '0;
        else if (xfer)                   chk_out <= chk_out ^ data;
    end
`endif
endmodule

// File: tb/tb_msg_rom_streamer.sv
// tb_msg_rom_streamer: scoreboard bench for msg_rom_streamer (timing, gap, loop, stall, abort, reset).
module tb_msg_rom_streamer;
    function automatic logic [1023:0] mk_img();
        logic [1023:0] r;
        r = '0;
        r[0*8 +: 8] = 8'h41; r[1*8 +: 8] = 8'h67; r[2*8 +: 8] = 8'h75; r[3*8 +: 8] = 8'h61;
        for (int i = 0; i < 32; i++) r[(32+i)*8 +: 8] = 8'h30 + 8'(i);
        r[96*8 +: 8] = 8'h48; r[97*8 +: 8] = 8'h65; r[98*8 +: 8] = 8'h6C;
        r[99*8 +: 8] = 8'h6C; r[100*8 +: 8] = 8'h6F;
        return r;
    endfunction

    localparam logic [1023:0] IMG = mk_img();

    logic        clk = 0, rst_n = 0, start = 0, loop = 0, abort = 0;
    logic [1:0]  msg_sel = 0;
    logic [15:0] gap_div = 0;
    logic        busy, done;
`ifdef MSG_CHKSUM_EN
    logic [7:0]  chk_out;
`endif

    msg_rom_streamer_if #(.DATA_W(8)) s ();

    msg_rom_streamer #(.ROM_IMAGE(IMG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_sel(msg_sel), .loop(loop),
        .gap_div(gap_div), .abort(abort), .out(s), .busy(busy), .done(done)
`ifdef MSG_CHKSUM_EN
        , .chk_out(chk_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, xfers = 0, dones = 0, cyc = 0;
    logic [7:0]  q[$];
    int          stamps[$];
    logic [31:0] e;
    logic        stall_prev = 0, abort_prev = 0;
    logic [7:0]  data_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rb(input int a);
        return IMG[a*8 +: 8];
    endfunction

    task automatic push_msg(input int sel);
        for (int i = 0; i < 32; i++) begin
            if (rb(sel*32 + i) == 8'h00) break;
            q.push_back(rb(sel*32 + i));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(input int sel, input int gd, input logic lp);
        msg_sel = 2'(sel);
        gap_div = 16'(gd);
        loop    = lp;
        start   = 1;
        tick(1);
        start   = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_xfers(input string tag, input int target, input int budget);
        int k = 0;
        while (xfers < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, xfers, target);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (s.valid && s.ready) begin
                e = q.size() != 0 ? 32'(q.pop_front()) : 32'hFFFF_FFFF;
                check("sb_data", s.data, e);
                xfers++;
                stamps.push_back(cyc);
            end
            if (stall_prev && !abort_prev) begin
                check("stall_valid", s.valid, 1);
                check("stall_data", s.data, data_prev);
            end
            if (done) dones++;
        end
        stall_prev = rst_n && s.valid && !s.ready;
        data_prev  = s.data;
        abort_prev = abort;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v, d, b;
        int x0, d0;
        s.ready = 1;
        tick(3);
        rst_n = 1;
        tick(1);
        check("rst_busy", busy, 0);
        check("rst_valid", s.valid, 0);
        check("rst_done", done, 0);
        check("rst_data", s.data, 0);
`ifdef MSG_CHKSUM_EN
        check("rst_chk", chk_out, 0);
`endif

        // One-shot "Agua", no gap: cycle-exact valid/done/busy pattern.
        v = '0; d = '0; b = '0; x0 = xfers; d0 = dones;
        push_msg(0);
        go(0, 0, 0);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            v[n] = s.valid; d[n] = done; b[n] = busy;
            @(posedge clk);
            #2;
        end
        check("t1_valid_cycles", v, 12'h154);
        check("t1_done_cycle", d, 12'h400);
        check("t1_busy_cycles", b, 12'h7FE);
        check("t1_xfers", xfers - x0, 4);
        check("t1_q_empty", q.size(), 0);
`ifdef MSG_CHKSUM_EN
        check("t1_chk", chk_out, 8'h32);
`endif

        // Gap of 3 idle cycles: period 5.
        x0 = xfers; d0 = dones; stamps.delete();
        push_msg(0);
        go(0, 3, 0);
        wait_idle("t2_idle", 60);
        check("t2_xfers", xfers - x0, 4);
        check("t2_done", dones - d0, 1);
        for (int i = 1; i < stamps.size(); i++) check("t2_period", stamps[i] - stamps[i-1], 5);

        // Full-slot message, with an ignored start and msg_sel/gap_div changes mid-stream.
        x0 = xfers; d0 = dones; stamps.delete();
        push_msg(1);
        go(1, 0, 0);
        tick(5);
        msg_sel = 0; gap_div = 7; start = 1;
        tick(1);
        start = 0;
        wait_idle("t3_idle", 200);
        check("t3_xfers", xfers - x0, 32);
        check("t3_done", dones - d0, 1);
        check("t3_span", stamps[31] - stamps[0], 62);
        check("t3_q_empty", q.size(), 0);

        // Looping: continuous with no wrap penalty; drop loop during the 2nd pass.
        x0 = xfers; d0 = dones; stamps.delete();
        push_msg(0); push_msg(0);
        go(0, 0, 1);
        wait_xfers("t4_reach5", x0 + 5, 40);
        loop = 0;
        wait_idle("t4_idle", 60);
        check("t4_xfers", xfers - x0, 8);
        check("t4_done", dones - d0, 1);
        check("t4_wrap_period", stamps[4] - stamps[3], 2);
        check("t4_q_empty", q.size(), 0);

        // Back-pressure for 7 EMIT cycles, then abort in the middle of the message.
        x0 = xfers; d0 = dones;
        q.push_back(rb(96)); q.push_back(rb(97));
        s.ready = 0;
        go(3, 0, 0);
        tick(8);
        s.ready = 1;
        wait_xfers("t5_reach2", x0 + 2, 20);
        abort = 1;
        tick(1);
        abort = 0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_valid", s.valid, 0);
        tick(2);
        check("t5_no_done", dones - d0, 0);
        check("t5_q_empty", q.size(), 0);
        push_msg(3);
        go(3, 1, 0);
        wait_idle("t5_restart_idle", 60);
        check("t5_restart_xfers", xfers - x0, 7);
        check("t5_restart_done", dones - d0, 1);

        // Empty slot with loop=1: no transfer, one done.
        x0 = xfers; d0 = dones;
        go(2, 0, 1);
        wait_idle("t6_idle", 20);
        loop = 0;
        check("t6_xfers", xfers - x0, 0);
        check("t6_done", dones - d0, 1);

        // Asynchronous reset mid-stream returns outputs to reset values at once.
        d0 = dones;
        s.ready = 0;
        go(1, 0, 0);
        tick(3);
        rst_n = 0;
        #1;
        check("t7_busy", busy, 0);
        check("t7_valid", s.valid, 0);
        check("t7_done", done, 0);
        check("t7_data", s.data, 0);
        tick(2);
        rst_n = 1;
        tick(1);
        s.ready = 1;
        x0 = xfers;
        push_msg(0);
        go(0, 0, 0);
        wait_idle("t7_after_idle", 40);
        check("t7_after_xfers", xfers - x0, 4);
        check("t7_after_done", dones - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
